// File: rtl/g_issue_stage_pkg.sv
// rtl/g_issue_stage_pkg.sv - shared widths, instruction fields, classes and FSM states for the issue stage
package g_issue_stage_pkg;

    localparam int W_RD   = 4;
    localparam int W_OPR  = 32;
    localparam int W_INSN = 32;
    localparam int W_CNT  = 16;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RA_MSB  = 25;
    localparam int RA_LSB  = 22;
    localparam int RB_MSB  = 21;
    localparam int RB_LSB  = 18;
    localparam int IMM_MSB = 15;

    typedef enum logic [1:0] {
        CLS_R = 2'b00,
        CLS_I = 2'b01,
        CLS_S = 2'b10,
        CLS_N = 2'b11
    } insn_class_e;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_HAZ   = 2'd2;
    localparam logic [1:0] ST_BP    = 2'd3;

    function automatic logic writes_dest(input logic [1:0] cls);
        return (cls == CLS_R) || (cls == CLS_I);
    endfunction

endpackage

// File: rtl/g_issue_decode.sv
// rtl/g_issue_decode.sv - combinational field split, class, second read index and immediate extension
module g_issue_decode
    import g_issue_stage_pkg::*;
(
    input  logic [W_INSN-1:0] insn_i,
    output logic [5:0]        op_o,
    output logic [1:0]        cls_o,
    output logic [W_RD-1:0]   ra_o,
    output logic [W_RD-1:0]   r1_o,
    output logic [W_OPR-1:0]  imm_ext_o
);

    logic [W_RD-1:0] rb;
    logic            unused_bits;

    assign op_o  = insn_i[OP_MSB:OP_LSB];
    assign cls_o = op_o[5:4];
    assign ra_o  = insn_i[RA_MSB:RA_LSB];
    assign rb    = insn_i[RB_MSB:RB_LSB];

    // I and N never read rb; pointing r1 at ra keeps a stale rb from raising a hazard
    assign r1_o = ((cls_o == CLS_I) || (cls_o == CLS_N)) ? ra_o : rb;

    assign imm_ext_o   = {{(W_OPR-IMM_MSB-1){insn_i[IMM_MSB]}}, insn_i[IMM_MSB:0]};
    assign unused_bits = ^insn_i[RB_LSB-1:IMM_MSB+1];

endmodule

// File: rtl/g_issue_stage.sv
// rtl/g_issue_stage.sv - decode latch plus issue register with hazard/backpressure stall and dest reservation
module g_issue_stage
    import g_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid_i,
    input  logic [W_INSN-1:0] inst_i,
    output logic              inst_ready_o,
    input  logic              flush_i,
    output logic [W_RD-1:0]   r0_o,
    output logic [W_RD-1:0]   r1_o,
    output logic              w_reserve_o,
    input  logic [W_OPR-1:0]  r_opr0_i,
    input  logic [W_OPR-1:0]  r_opr1_i,
    input  logic              reserved_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [5:0]        ex_op_o,
    output logic [W_RD-1:0]   ex_rd_o,
    output logic [W_OPR-1:0]  ex_opr0_o,
    output logic [W_OPR-1:0]  ex_opr1_o,
    output logic [W_CNT-1:0]  stall_cnt_o
);

    logic [1:0]        state_q, state_d;
    logic [W_INSN-1:0] d_insn_q, d_insn_d;
    logic              ex_valid_q, ex_valid_d;
    logic [5:0]        ex_op_q, ex_op_d;
    logic [W_RD-1:0]   ex_rd_q, ex_rd_d;
    logic [W_OPR-1:0]  ex_opr0_q, ex_opr0_d;
    logic [W_OPR-1:0]  ex_opr1_q, ex_opr1_d;
    logic [W_CNT-1:0]  stall_cnt_q, stall_cnt_d;

    logic [5:0]        dec_op;
    logic [1:0]        dec_cls;
    logic [W_RD-1:0]   dec_ra;
    logic [W_RD-1:0]   dec_r1;
    logic [W_OPR-1:0]  dec_imm;
    logic              d_valid;
    logic              fire;
    logic              accept;

    g_issue_decode u_decode (
        .insn_i    (d_insn_q),
        .op_o      (dec_op),
        .cls_o     (dec_cls),
        .ra_o      (dec_ra),
        .r1_o      (dec_r1),
        .imm_ext_o (dec_imm)
    );

    assign d_valid      = (state_q != ST_EMPTY);
    assign fire         = d_valid && !reserved_i && (!ex_valid_q || ex_ready_i);
    assign inst_ready_o = !d_valid || fire;
    assign accept       = inst_valid_i && inst_ready_o && !flush_i;
    assign w_reserve_o  = fire && writes_dest(dec_cls) && !flush_i;

    assign r0_o        = dec_ra;
    assign r1_o        = dec_r1;
    assign ex_valid_o  = ex_valid_q;
    assign ex_op_o     = ex_op_q;
    assign ex_rd_o     = ex_rd_q;
    assign ex_opr0_o   = ex_opr0_q;
    assign ex_opr1_o   = ex_opr1_q;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        d_insn_d    = d_insn_q;
        ex_valid_d  = ex_valid_q;
        ex_op_d     = ex_op_q;
        ex_rd_d     = ex_rd_q;
        ex_opr0_d   = ex_opr0_q;
        ex_opr1_d   = ex_opr1_q;
        stall_cnt_d = stall_cnt_q;

        if (d_valid && reserved_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + W_CNT'(1);
        end

        // flush overrides any fire or accept happening on the same edge
        if (flush_i) begin
            state_d    = ST_EMPTY;
            ex_valid_d = 1'b0;
        end else begin
            if (fire) begin
                ex_valid_d = 1'b1;
                ex_op_d    = dec_op;
                ex_rd_d    = dec_ra;
                ex_opr0_d  = r_opr0_i;
                ex_opr1_d  = (dec_cls == CLS_I) ? dec_imm : r_opr1_i;
            end else if (ex_ready_i) begin
                ex_valid_d = 1'b0;
            end

            if (accept) begin
                state_d  = ST_HOLD;
                d_insn_d = inst_i;
            end else if (fire) begin
                state_d = ST_EMPTY;
            end else if (d_valid) begin
                state_d = reserved_i ? ST_HAZ : ST_BP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            d_insn_q    <= '0;
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_rd_q     <= '0;
            ex_opr0_q   <= '0;
            ex_opr1_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            d_insn_q    <= d_insn_d;
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_opr0_q   <= ex_opr0_d;
            ex_opr1_q   <= ex_opr1_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_g_issue_stage.sv
// tb/tb_g_issue_stage.sv - directed and randomized checks of g_issue_stage against a behavioural model
module tb_g_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic        inst_ready_o;
    logic        flush_i;
    logic [3:0]  r0_o, r1_o;
    logic        w_reserve_o;
    logic [31:0] r_opr0_i, r_opr1_i;
    logic        reserved_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [5:0]  ex_op_o;
    logic [3:0]  ex_rd_o;
    logic [31:0] ex_opr0_o, ex_opr1_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] regs [16];

    always #5 clk = ~clk;

    assign r_opr0_i = regs[r0_o];
    assign r_opr1_i = regs[r1_o];

    g_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_ready_o (inst_ready_o),
        .flush_i      (flush_i),
        .r0_o         (r0_o),
        .r1_o         (r1_o),
        .w_reserve_o  (w_reserve_o),
        .r_opr0_i     (r_opr0_i),
        .r_opr1_i     (r_opr1_i),
        .reserved_i   (reserved_i),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready_i),
        .ex_op_o      (ex_op_o),
        .ex_rd_o      (ex_rd_o),
        .ex_opr0_o    (ex_opr0_o),
        .ex_opr1_o    (ex_opr1_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    int tests = 0;
    int fails = 0;

    // reference model: one held instruction and one issued record
    logic        m_dv, m_ev, n_dv, n_ev;
    logic [31:0] m_insn, n_insn;
    logic [5:0]  m_op, n_op;
    logic [3:0]  m_rd, n_rd;
    logic [31:0] m_o0, m_o1, n_o0, n_o1;
    int          m_cnt, n_cnt;

    function automatic logic [1:0] cls_of(input logic [31:0] i);
        return i[31:30];
    endfunction

    function automatic logic [3:0] ra_of(input logic [31:0] i);
        return i[25:22];
    endfunction

    function automatic logic [3:0] src1_of(input logic [31:0] i);
        return (cls_of(i) == 2'b00 || cls_of(i) == 2'b10) ? i[21:18] : i[25:22];
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return (v >= 16'h8000) ? 32'(v) - 32'h0001_0000 : 32'(v);
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [15:0] imm);
        return {op, ra, rb, 2'b00, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dv = 0; m_ev = 0; m_insn = '0; m_op = '0; m_rd = '0;
        m_o0 = '0; m_o1 = '0; m_cnt = 0;
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                        input logic rsv, input logic er);
        logic e_fire, e_ready, e_wres;
        inst_valid_i = iv; inst_i = ins; flush_i = fl; reserved_i = rsv; ex_ready_i = er;
        #1;
        e_fire  = m_dv && !rsv && (!m_ev || er);
        e_ready = !m_dv || e_fire;
        e_wres  = e_fire && (cls_of(m_insn) <= 2'b01) && !fl;
        check("inst_ready", 32'(inst_ready_o), 32'(e_ready));
        check("w_reserve", 32'(w_reserve_o), 32'(e_wres));
        check("ex_valid", 32'(ex_valid_o), 32'(m_ev));
        check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        if (m_dv) begin
            check("r0", 32'(r0_o), 32'(ra_of(m_insn)));
            check("r1", 32'(r1_o), 32'(src1_of(m_insn)));
        end
        if (m_ev) begin
            check("ex_op", 32'(ex_op_o), 32'(m_op));
            check("ex_rd", 32'(ex_rd_o), 32'(m_rd));
            check("ex_opr0", ex_opr0_o, m_o0);
            check("ex_opr1", ex_opr1_o, m_o1);
        end
        n_dv = m_dv; n_ev = m_ev; n_insn = m_insn; n_op = m_op; n_rd = m_rd;
        n_o0 = m_o0; n_o1 = m_o1;
        n_cnt = (m_dv && rsv && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        if (fl) begin
            n_dv = 0;
            n_ev = 0;
        end else begin
            if (e_fire) begin
                n_ev = 1;
                n_op = m_insn[31:26];
                n_rd = ra_of(m_insn);
                n_o0 = regs[ra_of(m_insn)];
                n_o1 = (cls_of(m_insn) == 2'b01) ? sext16(m_insn[15:0]) : regs[src1_of(m_insn)];
            end else if (er) begin
                n_ev = 0;
            end
            if (iv && e_ready) begin
                n_dv = 1;
                n_insn = ins;
            end else if (e_fire) begin
                n_dv = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_dv = n_dv; m_ev = n_ev; m_insn = n_insn; m_op = n_op; m_rd = n_rd;
        m_o0 = n_o0; m_o1 = n_o1; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        inst_valid_i = 0; inst_i = '0; flush_i = 0; reserved_i = 0; ex_ready_i = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        check("rst_inst_ready", 32'(inst_ready_o), 32'd1);
        check("rst_r0", 32'(r0_o), 32'd0);
        check("rst_r1", 32'(r1_o), 32'd0);
        check("rst_w_reserve", 32'(w_reserve_o), 32'd0);
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        reset = 1;

        // R op ra=3 rb=5, no hazard
        step(1, mk(6'b00_0001, 4'd3, 4'd5, 16'h1234), 0, 0, 1); tick();
        step(0, '0, 0, 0, 1);
        check("r_r0", 32'(r0_o), 32'd3);
        check("r_r1", 32'(r1_o), 32'd5);
        check("r_reserve", 32'(w_reserve_o), 32'd1);
        tick();
        step(0, '0, 0, 0, 1);
        check("r_ex_valid", 32'(ex_valid_o), 32'd1);
        check("r_opr0", ex_opr0_o, regs[3]);
        check("r_opr1", ex_opr1_o, regs[5]);
        check("r_reserve_once", 32'(w_reserve_o), 32'd0);
        tick();

        // same op held off by reservation for 4 cycles
        step(1, mk(6'b00_0001, 4'd3, 4'd5, 16'h0), 0, 0, 1); tick();
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, 1, 1);
            check("haz_no_reserve", 32'(w_reserve_o), 32'd0);
            tick();
        end
        step(0, '0, 0, 0, 1);
        check("haz_stall_cnt", 32'(stall_cnt_o), 32'd4);
        check("haz_fire_reserve", 32'(w_reserve_o), 32'd1);
        tick();
        step(0, '0, 0, 0, 1); tick();

        // I op with negative immediate
        step(1, mk(6'b01_0010, 4'd7, 4'd9, 16'hFFFE), 0, 0, 1); tick();
        step(0, '0, 0, 0, 1);
        check("i_r1_is_ra", 32'(r1_o), 32'd7);
        check("i_reserve", 32'(w_reserve_o), 32'd1);
        tick();
        step(0, '0, 0, 0, 1);
        check("i_opr1_sext", ex_opr1_o, 32'hFFFF_FFFE);
        tick();

        // S op reads but never reserves
        step(1, mk(6'b10_0000, 4'd2, 4'd11, 16'h0), 0, 0, 1); tick();
        step(0, '0, 0, 0, 1);
        check("s_no_reserve", 32'(w_reserve_o), 32'd0);
        tick();
        step(0, '0, 0, 0, 1); tick();

        // backpressure with D and E both full
        step(1, mk(6'b00_0011, 4'd1, 4'd2, 16'h0), 0, 0, 0); tick();
        step(1, mk(6'b00_0100, 4'd4, 4'd6, 16'h0), 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0, 0);
            check("bp_inst_ready", 32'(inst_ready_o), 32'd0);
            check("bp_no_reserve", 32'(w_reserve_o), 32'd0);
            check("bp_e_stable", 32'(ex_rd_o), 32'd1);
            tick();
        end
        step(0, '0, 0, 0, 1); tick();
        step(0, '0, 0, 0, 1); tick();

        // flush on the fire cycle
        step(1, mk(6'b00_0101, 4'd8, 4'd9, 16'h0), 0, 0, 1); tick();
        step(0, '0, 1, 0, 1);
        check("fl_no_reserve", 32'(w_reserve_o), 32'd0);
        tick();
        step(0, '0, 0, 0, 1);
        check("fl_ex_valid", 32'(ex_valid_o), 32'd0);
        check("fl_inst_ready", 32'(inst_ready_o), 32'd1);
        tick();

        // reset while an instruction is held and stalled
        step(1, mk(6'b00_0110, 4'd10, 4'd12, 16'h0), 0, 0, 1); tick();
        step(0, '0, 0, 1, 1); tick();
        reserved_i = 0; ex_ready_i = 1;
        reset = 0;
        #1;
        check("mid_rst_ex_valid", 32'(ex_valid_o), 32'd0);
        check("mid_rst_inst_ready", 32'(inst_ready_o), 32'd1);
        check("mid_rst_stall", 32'(stall_cnt_o), 32'd0);
        check("mid_rst_reserve", 32'(w_reserve_o), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_reserve_edge", 32'(w_reserve_o), 32'd0);
        @(negedge clk);
        reset = 1;
        model_reset();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 15)] = $urandom;
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
